// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and state width.
// No logic, no latency.
// No flow control; pure declarations.
package serial_adder_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fa1b.sv
// fa1b: one-bit full adder cell, the arithmetic core of the bit-serial adder.
// Latency: purely combinational.
// Backpressure: none; always evaluates its inputs.
module fa1b (
   input  logic cin,
   input  logic x,
   input  logic y,
   output logic cout,
   output logic s
);

   // Sum and majority carry of the three input bits.
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder processing one LSB-first bit pair per cycle through fa1b.
// Latency: WIDTH cycles from accepted start to done; one add per WIDTH+1 cycles, back-to-back from DONE.
// Backpressure: start is ignored while busy; results are held until the next completion.
// Optional: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_cout;
   logic fa_s;
   logic load_c;

   fa1b u_fa (
      .cin  (carry_q),
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .cout (fa_cout),
      .s    (fa_s)
   );

   // Next-state: operand load on accepted start, one bit step per SHIFT cycle, result capture on the last step.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      load_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            load_c = start;
         end
         S_SHIFT: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
            carry_d = fa_cout;
            if (cnt_q == CNT_LAST) begin
               // Last step: the result register takes the sum including this bit,
               // so partial sums never reach the outputs.
               sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
               cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q during the last step is the carry into the MSB.
               ovf_d   = carry_q ^ fa_cout;
`endif
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            load_c = start;
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load_c) begin
         a_sr_d  = a;
         b_sr_d  = b;
         carry_d = cin;
         cnt_d   = '0;
         state_d = S_SHIFT;
      end
   end

   // State and datapath registers; reset aborts any add in flight and clears results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: random and directed adds checked against an arithmetic model.
// Latency and back-to-back spacing are checked per transaction by a scoreboard monitor.
// Busy-time garbage on start/a/b/cin must be ignored by the DUT.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
      bit           b2b;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   pushes = 0;
   int   dones  = 0;

   initial begin
      clk = 1'b0;
      #10;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t e;
      int u;
      int sx;
      int sy;
      int s;
      u  = int'(x) + int'(y) + int'(c);
      sx = (int'(x) >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
      sy = (int'(y) >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
      s  = sx + sy + int'(c);
      e.sum  = W'(u % (1 << W));
      e.cout = (u >= (1 << W));
      e.ovf  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
      e.acc  = 0;
      e.b2b  = 1'b0;
      return e;
   endfunction

   // Monitor: pops and compares on every done; otherwise outputs must hold the last result.
   initial begin
      exp_t e;
      exp_t held;
      int   busy_run;
      int   last_done;
      held.sum = '0; held.cout = 1'b0; held.ovf = 1'b0; held.acc = 0; held.b2b = 1'b0;
      busy_run  = 0;
      last_done = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held.sum = '0; held.cout = 1'b0; held.ovf = 1'b0;
            busy_run = 0;
         end else if (done) begin
            dones = dones + 1;
            if (sb.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_done got=1 exp=0 at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("sum", 32'(sum), 32'(e.sum));
               chk("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
               chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
               chk("latency", 32'(cyc - e.acc), 32'(W));
               chk("busy_cycles", 32'(busy_run), 32'(W));
               chk("busy_in_done", 32'(busy), 32'd0);
               if (e.b2b) begin
                  chk("b2b_spacing", 32'(cyc - last_done), 32'(W + 1));
               end
               held = e;
            end
            last_done = cyc;
            busy_run  = 0;
         end else begin
            chk("sum_hold", 32'(sum), 32'(held.sum));
            chk("cout_hold", 32'(cout), 32'(held.cout));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf_hold", 32'(ovf), 32'(held.ovf));
`endif
            if (busy) busy_run = busy_run + 1;
            else      busy_run = 0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // While busy, drive garbage that the DUT must ignore; when not busy, optionally hold start low.
   task automatic garbage();
      start = 1'($urandom_range(0, 1));
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
   endtask

   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
      exp_t e;
      while (busy) begin
         garbage();
         step();
      end
      e     = model(x, y, c);
      e.acc = cyc + 1;
      e.b2b = done;
      start = 1'b1;
      a     = x;
      b     = y;
      cin   = c;
      if (push) begin
         sb.push_back(e);
         pushes = pushes + 1;
      end
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         if (busy) garbage();
         else      start = 1'b0;
         step();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish at cycle %0d", cyc);
      bad = bad + 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      step();
      rst_n = 1'b1;
      step();

      // Directed cases, issued back-to-back where the DUT allows.
      op(8'h3C, 8'h5A, 1'b0, 1'b1);
      op(8'hFF, 8'hFF, 1'b1, 1'b1);
      op(8'hFF, 8'h01, 1'b0, 1'b1);
      op(8'h7F, 8'h01, 1'b0, 1'b1);
      idle(W + 3);
      op(8'h80, 8'h80, 1'b0, 1'b1);
      idle(W + 2);

      // Abort mid-add: reset for one cycle, no done may follow for this add.
      op(8'hAA, 8'h55, 1'b1, 1'b0);
      idle(3);
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      step();
      rst_n = 1'b1;
      idle(2);
      chk("post_abort_busy", 32'(busy), 32'd0);
      op(8'h10, 8'h20, 1'b0, 1'b1);
      idle(W + 2);

      // Random adds with random gaps (zero gap gives back-to-back starts).
      for (int i = 0; i < 40; i++) begin
         op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         idle($urandom_range(0, 2));
      end

      for (int i = 0; i < 4 * W; i++) begin
         if (sb.size() == 0 && !busy) break;
         idle(1);
      end
      start = 1'b0;
      idle(2);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("done_count", 32'(dones), 32'(pushes));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
